// File: rtl/key_load_ctrl.sv
// rtl/key_load_ctrl.sv - serial key loader that assembles and applies a locked-netlist key
//
// Purpose:
//   Shifts a key MSB first from a serial source into a KEY_W-bit register.
//   The key is exposed as valid only after the whole word has been received,
//   so the locked netlist never sees a partial key.
//
// Optional feature (compile-time macro KEY_PARITY_EN):
//   When KEY_PARITY_EN is defined, one extra bit follows the key. It must
//   equal the XOR of all key bits. On a mismatch the key is wiped and the
//   sticky err flag is set. When the macro is undefined, no extra bit is
//   consumed and err is tied low.
//
// Parameters:
//   KEY_W     key width in bits (2..256)
//   CNT_W     bit-counter width, 2**CNT_W must exceed KEY_W
//
// Ports:
//   C          clock, rising edge
//   R          asynchronous reset, active low
//   start      load request, sampled in IDLE and DONE only
//   abort      cancels a load in progress (SHIFT or CHECK)
//   src_valid  serial source presents a bit
//   src_bit    serial key bit, MSB first
//   src_ready  controller accepts a bit this cycle
//   key        key word driven to the locked netlist
//   key_valid  key is complete and applied
//   busy       load in progress
//   err        sticky load-error flag (parity mismatch)

module key_load_ctrl #(
  parameter int KEY_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic             src_valid,
  input  logic             src_bit,
  output logic             src_ready,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             last_bit;

  // A bit moves only when both sides agree in the same cycle.
  assign xfer     = src_valid & src_ready;
  assign last_bit = (cnt == CNT_W'(KEY_W - 1));
  assign key      = key_q;

`ifdef KEY_PARITY_EN
  logic parity_ok;
  logic err_q;

  // The trailing bit is compared with the XOR of the word already shifted in.
  assign parity_ok = (src_bit == (^key_q));
  assign err       = err_q;
`else
  assign err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // abort wins over a transfer presented in the same cycle
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer && last_bit) begin
`ifdef KEY_PARITY_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef KEY_PARITY_EN
        if (abort) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          state_nxt = parity_ok ? DONE : IDLE;
        end
`else
        // not reachable without the parity option; recover to IDLE
        state_nxt = IDLE;
`endif
      end
      DONE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode: handshake and status depend on the state alone
  // ---------------------------------------------------------------------
  always_comb begin
    src_ready = 1'b0;
    busy      = 1'b0;
    key_valid = 1'b0;
    case (state)
      SHIFT: begin
        src_ready = 1'b1;
        busy      = 1'b1;
      end
      CHECK: begin
`ifdef KEY_PARITY_EN
        src_ready = 1'b1;
        busy      = 1'b1;
`endif
      end
      DONE: begin
        key_valid = 1'b1;
      end
      default: begin
        src_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Key shift register and bit counter
  // ---------------------------------------------------------------------
  // The key register is cleared on every path back to IDLE and on every new
  // start, so IDLE always presents an all-zero key.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      key_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q <= '0;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            key_q <= '0;
            cnt   <= '0;
          end else if (xfer) begin
            key_q <= {key_q[KEY_W-2:0], src_bit};
            // the counter returns to zero on the final bit so it never
            // passes KEY_W-1
            cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
          end
        end
        CHECK: begin
`ifdef KEY_PARITY_EN
          if (abort) begin
            key_q <= '0;
            cnt   <= '0;
          end else if (xfer && !parity_ok) begin
            key_q <= '0;
          end
`else
          key_q <= '0;
          cnt   <= '0;
`endif
        end
        DONE: begin
          if (start) begin
            key_q <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          key_q <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_PARITY_EN
  // ---------------------------------------------------------------------
  // Sticky error flag: cleared by a new load, set by a parity mismatch,
  // left alone by abort.
  // ---------------------------------------------------------------------
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_q <= 1'b0;
          end
        end
        CHECK: begin
          if (!abort && xfer && !parity_ok) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          err_q <= err_q;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_key_load_ctrl.sv
// tb/tb_key_load_ctrl.sv - self-checking bench for key_load_ctrl with a word-level reference model
module tb_key_load_ctrl;

  localparam int KEY_W = 8;
`ifdef KEY_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             C;
  logic             R;
  logic             start;
  logic             abort;
  logic             src_valid;
  logic             src_bit;
  logic             src_ready;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             busy;
  logic             err;

  int checks;
  int errors;
  int edges;
  int kv_rise;
  logic kv_prev;

  // reference model: a load in progress, number of key bits received,
  // the accumulated word value, and the sticky status flags
  logic             m_loading;
  int               m_n;
  logic [KEY_W-1:0] m_acc;
  logic             m_valid;
  logic             m_err;

  key_load_ctrl #(.KEY_W(KEY_W), .CNT_W(4)) dut (
    .C(C), .R(R), .start(start), .abort(abort),
    .src_valid(src_valid), .src_bit(src_bit), .src_ready(src_ready),
    .key(key), .key_valid(key_valid), .busy(busy), .err(err)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_n       = 0;
    m_acc     = '0;
    m_valid   = 1'b0;
    m_err     = 1'b0;
  endtask

  // One clock edge of the behaviour, described at the word level.
  task automatic model_edge(input logic st, input logic ab, input logic v, input logic b);
    if (!m_loading) begin
      if (st) begin
        m_loading = 1'b1;
        m_n       = 0;
        m_acc     = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
      end
    end else if (ab) begin
      m_loading = 1'b0;
      m_n       = 0;
      m_acc     = '0;
    end else if (v) begin
      if (m_n < KEY_W) begin
        m_acc = KEY_W'((m_acc * 2) + b);
        m_n   = m_n + 1;
        if (m_n == KEY_W && PAR == 0) begin
          m_loading = 1'b0;
          m_valid   = 1'b1;
        end
      end else begin
        if (int'(b) == ($countones(m_acc) % 2)) begin
          m_valid = 1'b1;
        end else begin
          m_acc = '0;
          m_err = 1'b1;
        end
        m_loading = 1'b0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".key"},       64'(key),       64'(m_acc));
    chk({tag, ".key_valid"}, 64'(key_valid), 64'(m_valid));
    chk({tag, ".busy"},      64'(busy),      64'(m_loading));
    chk({tag, ".src_ready"}, 64'(src_ready), 64'(m_loading));
    chk({tag, ".err"},       64'(err),       64'(m_err));
  endtask

  task automatic step(input string tag, input logic st, input logic ab, input logic v, input logic b);
    start     = st;
    abort     = ab;
    src_valid = v;
    src_bit   = b;
    @(posedge C);
    #1;
    edges++;
    model_edge(st, ab, v, b);
    compare_all(tag);
    if (key_valid && !kv_prev) kv_rise = edges;
    kv_prev = key_valid;
  endtask

  task automatic send_key(input string tag, input logic [KEY_W-1:0] val);
    for (int i = KEY_W - 1; i >= 0; i--) begin
      step(tag, 1'b0, 1'b0, 1'b1, val[i]);
    end
  endtask

  task automatic send_parity(input string tag, input logic [KEY_W-1:0] val);
    if (PAR != 0) step(tag, 1'b0, 1'b0, 1'b1, ^val);
  endtask

  initial begin
    int e0;
    logic [KEY_W-1:0] word;
    checks    = 0;
    errors    = 0;
    edges     = 0;
    kv_rise   = -1;
    kv_prev   = 1'b0;
    R         = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    src_valid = 1'b0;
    src_bit   = 1'b0;
    model_reset();

    repeat (2) @(posedge C);
    #1;
    compare_all("reset");
    @(negedge C);
    R = 1'b1;

    // idle ignores stray source bits and abort
    step("idle_noise", 1'b0, 1'b1, 1'b1, 1'b1);

    // nominal load of A5, key_valid on the 9th edge counting the start edge
    e0 = edges;
    step("nom_start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_key("nom", 8'hA5);
    send_parity("nom_par", 8'hA5);
    chk("nom_key", 64'(key), 64'hA5);
    chk("nom_latency", 64'(kv_rise - e0), 64'(KEY_W + 1 + PAR));

    // abort is ignored once the key is applied
    step("done_abort", 1'b0, 1'b1, 1'b1, 1'b0);

    // reload from DONE: key wiped on the start edge, then 3C
    step("reload_start", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reload_clear_key", 64'(key), 64'h00);
    chk("reload_clear_valid", 64'(key_valid), 64'h0);
    send_key("reload", 8'h3C);
    send_parity("reload_par", 8'h3C);
    chk("reload_key", 64'(key), 64'h3C);

    // backpressure: two idle source cycles after bit 4, start held high
    e0 = edges;
    word = 8'hA5;
    step("bp_start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = KEY_W - 1; i >= 4; i--) step("bp_hi", 1'b1, 1'b0, 1'b1, word[i]);
    step("bp_gap0", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_gap_key", 64'(key), 64'h0A);
    step("bp_gap1", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_gap_key2", 64'(key), 64'h0A);
    for (int i = 3; i >= 0; i--) step("bp_lo", 1'b0, 1'b0, 1'b1, word[i]);
    send_parity("bp_par", 8'hA5);
    chk("bp_key", 64'(key), 64'hA5);
    chk("bp_latency", 64'(kv_rise - e0), 64'(KEY_W + 3 + PAR));

    // abort on bit 6 together with a valid bit
    step("ab_start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = KEY_W - 1; i >= 3; i--) step("ab_bits", 1'b0, 1'b0, 1'b1, word[i]);
    step("ab_hit", 1'b0, 1'b1, 1'b1, word[2]);
    chk("ab_key", 64'(key), 64'h00);
    chk("ab_busy", 64'(busy), 64'h0);
    step("ab_idle", 1'b0, 1'b0, 1'b1, 1'b1);

    // asynchronous reset after three bits of a load
    step("rst_start", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = KEY_W - 1; i >= 5; i--) step("rst_bits", 1'b0, 1'b0, 1'b1, word[i]);
    #2;
    R = 1'b0;
    #1;
    model_reset();
    chk("arst_key", 64'(key), 64'h00);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_valid", 64'(key_valid), 64'h0);
    chk("arst_ready", 64'(src_ready), 64'h0);
    @(negedge C);
    R = 1'b1;
    kv_prev = key_valid;
    step("arst_nostart", 1'b0, 1'b0, 1'b1, 1'b1);

`ifdef KEY_PARITY_EN
    step("par_ok_start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_key("par_ok", 8'hA5);
    step("par_ok_bit", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("par_ok_valid", 64'(key_valid), 64'h1);
    step("par_bad_start", 1'b1, 1'b0, 1'b0, 1'b0);
    send_key("par_bad", 8'hA5);
    step("par_bad_bit", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_bad_key", 64'(key), 64'h00);
    chk("par_bad_err", 64'(err), 64'h1);
    chk("par_bad_busy", 64'(busy), 64'h0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step("rand",
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 23) == 0),
           1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
